instr_mem_sync: RTL and testbench

INSTR_MEM_SYNC -- requirements
Module: instr_mem_sync

---
 rtl/instr_mem_sync.sv | 132 +++++++++++++
 tb/tb_instr_mem_sync.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_sync.sv
// ============================================================================
// Module   : instr_mem_sync
// Purpose  : Synchronous instruction memory with valid/ready fetch port,
//            byte-enabled load port and self-initialising fill on reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_sync #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] INIT_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_be,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] c_last = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [AW-1:0]   r_fill_cnt;
    logic [31:0]     r_mem [DEPTH];

    logic            r_rsp_valid;
    logic [31:0]     r_rsp_data;
    logic            r_rsp_err;

    logic            w_running;
    logic            w_req_accept;
    logic            w_req_err;
    logic [AW-1:0]   w_req_idx;
    logic            w_wr_ok;
    logic [AW-1:0]   w_wr_idx;

    // ------------------------------------------------------------------
    // Fill / run state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_INIT: if (r_fill_cnt == c_last) w_state_next = ST_RUN;
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fill_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_fill_cnt <= r_fill_cnt + AW'(1);
        end
    end

    assign w_running = (r_state == ST_RUN);
    assign busy      = (r_state == ST_INIT);

    // ------------------------------------------------------------------
    // Address decode: upper bits set means beyond the array
    // ------------------------------------------------------------------
    assign w_req_idx    = req_addr[AW+1:2];
    assign w_req_err    = (req_addr[1:0] != 2'b00) || (|req_addr[31:AW+2]);
    assign req_ready    = w_running && (!r_rsp_valid || rsp_ready);
    assign w_req_accept = req_valid && req_ready;

    assign w_wr_idx = wr_addr[AW+1:2];
    assign w_wr_ok  = wr_en && w_running && (wr_addr[1:0] == 2'b00)
                      && !(|wr_addr[31:AW+2]);

    // Array carries no reset; the INIT pass rewrites every word instead.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_fill_cnt] <= INIT_WORD;
        end else if (w_wr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    r_mem[w_wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response register: read-before-write on a same-word collision
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 32'h0;
            r_rsp_err   <= 1'b0;
        end else if (w_req_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_req_err;
            r_rsp_data  <= w_req_err ? INIT_WORD : r_mem[w_req_idx];
        end else if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_sync.sv
// ============================================================================
// Module   : tb_instr_mem_sync
// Purpose  : Directed self-checking bench for instr_mem_sync at DEPTH=16.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_sync;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_mem [16];

    instr_mem_sync #(
        .DEPTH     (16),
        .INIT_WORD (NOP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_be     (wr_be),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers: called at a negedge, return at the next negedge.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_be   = be;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] a, output logic v, output logic [31:0] d, output logic e);
        req_valid = 1'b1;
        req_addr  = a;
        rsp_ready = 1'b1;
        @(negedge clk);
        v = rsp_valid;
        d = rsp_data;
        e = rsp_err;
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
        wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0; wr_be = 4'h0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_err, req_ready, busy} !== 4'b0001 || rsp_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b e=%b rdy=%b busy=%b d=%h want v=0 e=0 rdy=0 busy=1 d=0",
                     rsp_valid, rsp_err, req_ready, busy, rsp_data);
        end
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            total++;
            if (busy !== 1'b1 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL init_cycle%0d: got busy=%b rdy=%b want busy=1 rdy=0", i, busy, req_ready);
            end
            @(negedge clk);
        end
        total++;
        if (busy !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL init_done: got busy=%b rdy=%b want busy=0 rdy=1", busy, req_ready);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== NOP || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL first_fetch: got v=%b d=%h e=%b want v=1 d=%h e=0", rsp_valid, rsp_data, rsp_err, NOP);
        end
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL rsp_clear: got v=%b want v=0", rsp_valid);
        end
        for (int i = 0; i < 16; i++) exp_mem[i] = NOP;
    endtask

    task automatic test_back_to_back();
        do_write(32'h0, 32'h0040_0293, 4'hF);
        do_write(32'h4, 32'h0060_0313, 4'hF);
        exp_mem[0] = 32'h0040_0293;
        exp_mem[1] = 32'h0060_0313;
        req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b1;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0040_0293 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first: got v=%b d=%h e=%b want v=1 d=00400293 e=0", rsp_valid, rsp_data, rsp_err);
        end
        req_addr = 32'h4;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0060_0313 || rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: got v=%b d=%h e=%b want v=1 d=00600313 e=0", rsp_valid, rsp_data, rsp_err);
        end
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain: got v=%b want v=0", rsp_valid);
        end
    endtask

    task automatic test_byte_enable();
        logic v, e;
        logic [31:0] d;
        do_write(32'h8, 32'h0000_AB00, 4'b0010);
        do_fetch(32'h8, v, d, e);
        total++;
        if (v !== 1'b1 || d !== 32'h0000_AB13 || e !== 1'b0) begin
            bad++;
            $display("FAIL byte_enable: got v=%b d=%h e=%b want v=1 d=0000ab13 e=0", v, d, e);
        end
        exp_mem[2] = 32'h0000_AB13;
        do_write(32'h8, 32'hFFFF_FFFF, 4'b0000);
        do_fetch(32'h8, v, d, e);
        total++;
        if (d !== 32'h0000_AB13) begin
            bad++;
            $display("FAIL zero_be: got d=%h want d=0000ab13", d);
        end
    endtask

    task automatic test_errors();
        logic v, e;
        logic [31:0] d;
        do_fetch(32'h2, v, d, e);
        total++;
        if (v !== 1'b1 || e !== 1'b1 || d !== NOP) begin
            bad++;
            $display("FAIL err_misaligned: got v=%b e=%b d=%h want v=1 e=1 d=%h", v, e, d, NOP);
        end
        do_fetch(32'h40, v, d, e);
        total++;
        if (v !== 1'b1 || e !== 1'b1 || d !== NOP) begin
            bad++;
            $display("FAIL err_range: got v=%b e=%b d=%h want v=1 e=1 d=%h", v, e, d, NOP);
        end
        do_fetch(32'h3C, v, d, e);
        total++;
        if (v !== 1'b1 || e !== 1'b0 || d !== NOP) begin
            bad++;
            $display("FAIL last_word: got v=%b e=%b d=%h want v=1 e=0 d=%h", v, e, d, NOP);
        end
        do_write(32'h40, 32'h1234_5678, 4'hF);
        do_write(32'h5, 32'h8765_4321, 4'hF);
        for (int i = 0; i < 16; i++) begin
            do_fetch(32'(i * 4), v, d, e);
            total++;
            if (d !== exp_mem[i] || e !== 1'b0) begin
                bad++;
                $display("FAIL dropped_write_word%0d: got d=%h e=%b want d=%h e=0", i, d, e, exp_mem[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        req_valid = 1'b1; req_addr = 32'h4; rsp_ready = 1'b0;
        @(negedge clk);
        req_addr = 32'h0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h0060_0313 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_cycle%0d: got v=%b d=%h rdy=%b want v=1 d=00600313 rdy=0",
                         k, rsp_valid, rsp_data, req_ready);
            end
            if (k < 2) @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_release_ready: got rdy=%b want rdy=1", req_ready);
        end
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0040_0293) begin
            bad++;
            $display("FAIL stall_next_req: got v=%b d=%h want v=1 d=00400293", rsp_valid, rsp_data);
        end
        req_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_collision_and_reset();
        logic v, e;
        logic [31:0] d;
        wr_en = 1'b1; wr_addr = 32'hC; wr_data = 32'hDEAD_BEEF; wr_be = 4'hF;
        req_valid = 1'b1; req_addr = 32'hC; rsp_ready = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; req_valid = 1'b0;
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== NOP) begin
            bad++;
            $display("FAIL collision_old: got v=%b d=%h want v=1 d=%h", rsp_valid, rsp_data, NOP);
        end
        @(negedge clk);
        do_fetch(32'hC, v, d, e);
        total++;
        if (d !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL collision_new: got d=%h want d=deadbeef", d);
        end
        req_valid = 1'b1; req_addr = 32'h0; rsp_ready = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0 || rsp_data !== 32'h0) begin
            bad++;
            $display("FAIL midreset: got v=%b busy=%b rdy=%b d=%h want v=0 busy=1 rdy=0 d=0",
                     rsp_valid, busy, req_ready, rsp_data);
        end
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (16) @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL refill_done: got busy=%b want busy=0", busy);
        end
        do_fetch(32'hC, v, d, e);
        total++;
        if (d !== NOP || e !== 1'b0) begin
            bad++;
            $display("FAIL refill_word3: got d=%h e=%b want d=%h e=0", d, e, NOP);
        end
        do_fetch(32'h0, v, d, e);
        total++;
        if (d !== NOP) begin
            bad++;
            $display("FAIL refill_word0: got d=%h want d=%h", d, NOP);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_byte_enable();
        test_errors();
        test_backpressure();
        test_collision_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
